// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: RV opcodes, funct3
// encodings for ALU and branch compares, the M-extension funct7 and the
// stage FSM state type.
package ex_pkg;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // funct7 marking the M extension on OP
    localparam logic [6:0] F7_MUL = 7'b0000001;

    // Stage FSM: IDLE accepts work, BUSY iterates the multiplier,
    // DONE is the single cycle that writes the product to the output regs.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ex_state_e;

    // True for the only M-extension op this stage executes iteratively.
    function automatic logic is_mul_insn(input logic [31:0] ir);
        return (ir[6:0] == OPC_OP) && (ir[31:25] == F7_MUL) && (ir[14:12] == F3_ADD);
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier. One partial-product step per cycle for XLEN
// cycles after start; only the low XLEN bits of the product are kept since
// the pipeline only implements MUL (not MULH*). abort drops any work in flight.
module ex_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last_step,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    logic            running;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;

    // The step taken this cycle is the final one; lets the owner move to DONE
    // on the same edge that completes the accumulation.
    assign last_step = running & (cnt == CW'(XLEN - 1));
    assign product   = acc;

    // Operand load on start, then shift multiplicand left / multiplier right,
    // adding the multiplicand whenever the current multiplier LSB is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running <= 1'b1;
                cnt     <= '0;
                mcand   <= a;
                mplier  <= b;
                acc     <= '0;
            end else if (running) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (last_step) begin
                    running <= 1'b0;
                    cnt     <= '0;
                    done    <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage_hs.sv
// Execute stage with valid/ready on both sides. ALU, comparator and branch
// resolution are single-cycle; MUL runs on the iterative multiplier.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds its payload stable while valid & ~ready; ready may
// depend combinationally on the consumer side (in_ready uses out_ready) but
// valid never depends on ready. flush kills the held result and any multiply.
module ex_stage_hs
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     ir_out,
    output logic [XLEN-1:0] alu_out,
    output logic            comp_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] b_out,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target
);
    localparam int SHW = $clog2(XLEN);

    ex_state_e       state;
    ex_state_e       state_nxt;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            accept;
    logic            is_mul;
    logic            mul_start;
    logic            mul_last;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    logic [XLEN-1:0] res_alu;
    logic            res_comp;
    logic            res_taken;
    logic [XLEN-1:0] res_target;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];

    // Integer ALU for OP / OP-IMM. sub_ok is set only for register-register
    // ops, because on OP-IMM ir[30] is immediate bits, not a SUB select.
    function automatic logic [XLEN-1:0] alu_f(input logic [2:0] fn,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y,
                                              input logic alt,
                                              input logic sub_ok);
        logic [XLEN-1:0] r;
        logic [SHW-1:0]  sh;
        sh = y[SHW-1:0];
        r  = '0;
        case (fn)
            F3_ADD:  r = (sub_ok && alt) ? (x - y) : (x + y);
            F3_SLL:  r = x << sh;
            F3_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            F3_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
            F3_XOR:  r = x ^ y;
            F3_SR: begin
                if (alt) r = $signed(x) >>> sh;
                else     r = x >> sh;
            end
            F3_OR:   r = x | y;
            F3_AND:  r = x & y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Comparator bit reported on comp_out for SLT/SLTU; zero for other ALU ops.
    function automatic logic slt_bit(input logic [2:0] fn,
                                     input logic [XLEN-1:0] x,
                                     input logic [XLEN-1:0] y);
        logic r;
        r = 1'b0;
        if (fn == F3_SLT)  r = $signed(x) < $signed(y);
        if (fn == F3_SLTU) r = x < y;
        return r;
    endfunction

    // Branch condition; the two reserved funct3 codes never take.
    function automatic logic br_cond(input logic [2:0] fn,
                                     input logic [XLEN-1:0] x,
                                     input logic [XLEN-1:0] y);
        logic r;
        r = 1'b0;
        case (fn)
            BR_EQ:   r = (x == y);
            BR_NE:   r = (x != y);
            BR_LT:   r = ($signed(x) <  $signed(y));
            BR_GE:   r = ($signed(x) >= $signed(y));
            BR_LTU:  r = (x <  y);
            BR_GEU:  r = (x >= y);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Decode and compute the single-cycle result for the instruction on the input.
    always_comb begin
        res_alu    = '0;
        res_comp   = 1'b0;
        res_taken  = 1'b0;
        res_target = pc + imm;
        is_mul     = 1'b0;
        case (opcode)
            OPC_LUI:   res_alu = imm;
            OPC_AUIPC: res_alu = pc + imm;
            OPC_LOAD,
            OPC_STORE: res_alu = a + imm;
            OPC_OPIMM: begin
                res_alu  = alu_f(f3, a, imm, ir[30], 1'b0);
                res_comp = slt_bit(f3, a, imm);
            end
            OPC_OP: begin
                if (f7 == F7_MUL) begin
                    // Only MUL is iterative; other M ops (and MUL when disabled) yield 0.
                    is_mul = MUL_EN && is_mul_insn(ir);
                end else begin
                    res_alu  = alu_f(f3, a, b, ir[30], 1'b1);
                    res_comp = slt_bit(f3, a, b);
                end
            end
            OPC_JAL: begin
                res_alu   = pc + XLEN'(4);
                res_taken = 1'b1;
            end
            OPC_JALR: begin
                res_alu    = pc + XLEN'(4);
                res_taken  = 1'b1;
                res_target = (a + imm) & ~XLEN'(1);
            end
            OPC_BRANCH: begin
                res_alu   = pc + imm;
                res_comp  = br_cond(f3, a, b);
                res_taken = res_comp;
            end
            default: ;
        endcase
    end

    assign in_ready  = ~rst & (state == IDLE) & (~out_valid | out_ready) & ~flush;
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & is_mul;

    ex_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .abort     (flush),
        .a         (a),
        .b         (b),
        .last_step (mul_last),
        .done      (mul_done),
        .product   (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: a multiply parks the stage in BUSY until the last step,
    // then one DONE cycle to publish the product. flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) state_nxt = BUSY;
                BUSY:    if (mul_last)  state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output registers: load on accept, publish the product in DONE, drop
    // out_valid after a transfer. A multiply latches its side fields at accept
    // and keeps out_valid low until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ir_out    <= '0;
            alu_out   <= '0;
            comp_out  <= 1'b0;
            pc_out    <= '0;
            b_out     <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            ir_out    <= ir;
            pc_out    <= pc;
            b_out     <= b;
            comp_out  <= res_comp;
            br_taken  <= res_taken;
            br_target <= res_target;
            if (is_mul) begin
                alu_out   <= '0;
                out_valid <= 1'b0;
            end else begin
                alu_out   <= res_alu;
                out_valid <= 1'b1;
            end
        end else if ((state == DONE) && mul_done) begin
            alu_out   <= mul_product;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_hs.sv
// Testbench for ex_stage_hs (XLEN=32, MUL_EN=1): directed cases for latency,
// backpressure, flush and reset, then randomized traffic against a
// scoreboard fed by an instruction-level reference model.
module tb_ex_stage_hs;
    localparam int W = 32 + 32 + 1 + 32 + 32 + 1 + 32;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OPR = 7'b0110011,
                           JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011;

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic        comp_out, br_taken;
    logic [31:0] ir, imm, a, b, pc, ir_out, alu_out, pc_out, b_out, br_target;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] snap;
    logic         hold_pending;
    int           total, bad;

    ex_stage_hs #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .imm(imm), .a(a), .b(b), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ir_out(ir_out),
        .alu_out(alu_out), .comp_out(comp_out), .pc_out(pc_out), .b_out(b_out),
        .br_taken(br_taken), .br_target(br_target)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Result of one instruction as the architecture defines it.
    function automatic logic [W-1:0] model(input logic [31:0] i, im, x, y, p);
        logic [31:0] r, tg, opnd;
        logic        c, t;
        logic [2:0]  f;
        r = 0; c = 0; t = 0; tg = p + im; f = i[14:12];
        case (i[6:0])
            LUI:         r = im;
            AUIPC:       r = p + im;
            LOAD, STORE: r = x + im;
            OPIMM, OPR: begin
                opnd = (i[6:0] == OPR) ? y : im;
                if (i[6:0] == OPR && i[31:25] == 7'b0000001) begin
                    r = (f == 3'd0) ? x * y : 32'd0;
                end else begin
                    case (f)
                        3'd0: r = (i[6:0] == OPR && i[30]) ? x - opnd : x + opnd;
                        3'd1: r = x << opnd[4:0];
                        3'd2: begin c = $signed(x) < $signed(opnd); r = {31'd0, c}; end
                        3'd3: begin c = x < opnd; r = {31'd0, c}; end
                        3'd4: r = x ^ opnd;
                        3'd5: begin
                            if (i[30]) r = $signed(x) >>> opnd[4:0];
                            else       r = x >> opnd[4:0];
                        end
                        3'd6: r = x | opnd;
                        default: r = x & opnd;
                    endcase
                end
            end
            JAL:  begin r = p + 4; t = 1; end
            JALR: begin r = p + 4; t = 1; tg = (x + im) & 32'hFFFF_FFFE; end
            BRANCH: begin
                r = p + im;
                case (f)
                    3'd0: c = (x == y);
                    3'd1: c = (x != y);
                    3'd4: c = $signed(x) < $signed(y);
                    3'd5: c = $signed(x) >= $signed(y);
                    3'd6: c = x < y;
                    3'd7: c = x >= y;
                    default: c = 0;
                endcase
                t = c;
            end
            default: ;
        endcase
        return {i, r, c, p, y, t, tg};
    endfunction

    function automatic logic [W-1:0] cur_out();
        return {ir_out, alu_out, comp_out, pc_out, b_out, br_taken, br_target};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    // Samples on the falling edge: held outputs must not move, each output
    // transfer pops the oldest expected result, each input transfer pushes one.
    initial begin
        hold_pending = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (hold_pending) begin
                total++;
                if (!out_valid || cur_out() !== snap) begin
                    bad++;
                    $display("FAIL hold: got v=%0b %h want v=1 %h", out_valid, cur_out(), snap);
                end
            end
            if (rst || flush) begin
                exp_q.delete();
                hold_pending = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got %h want nothing", cur_out());
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        if (cur_out() !== e) begin
                            bad++;
                            $display("FAIL result: got %h want %h", cur_out(), e);
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(ir, imm, a, b, pc));
                hold_pending = out_valid && !out_ready;
                snap = cur_out();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] i, im, x, y, p);
        int n;
        in_valid = 1'b1; ir = i; imm = im; a = x; b = y; pc = p;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout: got in_ready=0 want 1");
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    logic rnd_ready;
    initial begin
        rnd_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (rnd_ready) #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt, nrdy;
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ir = 0; imm = 0; a = 0; b = 0; pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_br_target", br_target, 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

        // ADD / SUB
        issue(mk(7'h00, 3'd0, OPR), 0, 5, 7, 32'h40);
        @(negedge clk);
        check("add_valid", {31'd0, out_valid}, 1);
        check("add_alu", alu_out, 12);
        @(posedge clk); #1;
        issue(mk(7'h20, 3'd0, OPR), 0, 5, 7, 32'h44);
        @(negedge clk);
        check("sub_alu", alu_out, 32'hFFFF_FFFE);
        @(posedge clk); #1;

        // BLT / BLTU
        issue(mk(7'h00, 3'b100, BRANCH), 32'h20, 32'hFFFF_FFFF, 1, 32'h100);
        @(negedge clk);
        check("blt_comp", {31'd0, comp_out}, 1);
        check("blt_taken", {31'd0, br_taken}, 1);
        check("blt_target", br_target, 32'h120);
        @(posedge clk); #1;
        issue(mk(7'h00, 3'b110, BRANCH), 32'h20, 32'hFFFF_FFFF, 1, 32'h100);
        @(negedge clk);
        check("bltu_comp", {31'd0, comp_out}, 0);
        check("bltu_taken", {31'd0, br_taken}, 0);
        @(posedge clk); #1;

        // MUL latency
        issue(mk(7'h01, 3'd0, OPR), 0, 32'hFFFF_FFFF, 3, 32'h300);
        cnt = 0; nrdy = 0;
        forever begin
            @(negedge clk);
            if (out_valid || cnt > 100) break;
            cnt++;
            if (!in_ready) nrdy++;
        end
        check("mul_latency", cnt, 33);
        check("mul_in_ready_low", nrdy, 33);
        check("mul_alu", alu_out, 32'hFFFF_FFFD);
        @(posedge clk); #1;

        // Backpressure
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        issue(mk(7'h00, 3'd0, OPR), 0, 1, 2, 32'h400);
        in_valid = 1'b1; ir = mk(7'h20, 3'd0, OPR); a = 10; b = 3; pc = 32'h404; imm = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            check("bp_alu_frozen", alu_out, 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", {31'd0, out_valid}, 1);
        check("bp_next_alu", alu_out, 7);
        @(posedge clk); #1;

        // Flush mid-multiply
        issue(mk(7'h01, 3'd0, OPR), 0, 6, 7, 32'h500);
        repeat (9) @(posedge clk);
        #1 do_flush();
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 0);
        check("flush_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        issue(mk(7'h00, 3'd0, OPR), 0, 100, 23, 32'h504);
        @(negedge clk);
        check("flush_add_alu", alu_out, 123);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("flush_no_stale_mul", cnt, 0);
        @(posedge clk); #1;

        // JALR
        issue(mk(7'h00, 3'd0, JALR), 4, 32'h1003, 0, 32'h200);
        @(negedge clk);
        check("jalr_alu", alu_out, 32'h204);
        check("jalr_target", br_target, 32'h1006);
        check("jalr_taken", {31'd0, br_taken}, 1);
        @(posedge clk); #1;

        // Reset mid-multiply
        issue(mk(7'h01, 3'd0, OPR), 0, 9, 9, 32'h600);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 0);
        check("rst_mid_alu", alu_out, 0);
        check("rst_mid_pc", pc_out, 0);
        check("rst_mid_ir", ir_out, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_after_ready", {31'd0, in_ready}, 1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_no_stale_mul", cnt, 0);
        @(posedge clk); #1;

        // Randomized traffic
        rnd_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ri;
            ri = $urandom;
            case ($urandom_range(0, 10))
                0: ri[6:0] = LUI;
                1: ri[6:0] = AUIPC;
                2: ri[6:0] = LOAD;
                3: ri[6:0] = STORE;
                4: ri[6:0] = OPIMM;
                5: begin ri[6:0] = OPR; ri[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
                6: ri[6:0] = JAL;
                7: ri[6:0] = JALR;
                8: ri[6:0] = BRANCH;
                9: ri[6:0] = 7'b1111111;
                default: begin
                    ri[6:0] = OPR; ri[31:25] = 7'h01;
                    if ($urandom_range(0, 3) != 0) ri[14:12] = 3'd0;
                end
            endcase
            issue(ri, $urandom, pick_val(), pick_val(), $urandom);
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1 do_flush();
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
